// File: rtl/fifo_push_arbiter_if.sv
// rtl/fifo_push_arbiter_if.sv - push-side bundle between producers, arbiter and FIFO
// Statistics ports exist only when FIFO_PUSH_ARB_STATS_EN is defined.
interface fifo_push_arbiter_if #(
  parameter int width = 16,
  parameter int depth = 8,
  parameter int n_src = 4
);
  localparam int cw = $clog2(depth + 1);

  logic [n_src-1:0]       req;
  logic [n_src*width-1:0] data_in;
  logic [n_src-1:0]       gnt;
  logic [width-1:0]       fifo_din;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_pndng;
  logic                   fifo_full;
  logic [cw-1:0]          count;
  logic                   ovf_err;
`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [n_src*16-1:0]    grant_cnt;
  logic [15:0]            stall_cnt;
`endif

  modport master (
    input  req, data_in, fifo_pop, fifo_pndng, fifo_full,
`ifdef FIFO_PUSH_ARB_STATS_EN
    output grant_cnt, stall_cnt,
`endif
    output gnt, fifo_din, fifo_push, count, ovf_err
  );

  modport slave (
    output req, data_in, fifo_pop, fifo_pndng, fifo_full,
`ifdef FIFO_PUSH_ARB_STATS_EN
    input  grant_cnt, stall_cnt,
`endif
    input  gnt, fifo_din, fifo_push, count, ovf_err
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin push arbiter in front of a shared fifo_flops
// Optional per-source grant and stall counters under FIFO_PUSH_ARB_STATS_EN.
module fifo_push_arbiter #(
  parameter int width = 16,
  parameter int depth = 8,
  parameter int n_src = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_push_arbiter_if.master     bus
);
  localparam int cw = $clog2(depth + 1);
  localparam int pw = (n_src > 1) ? $clog2(n_src) : 1;
  localparam logic [cw-1:0] depth_c = cw'(depth);
  localparam logic [cw-1:0] one_c   = cw'(1);
  localparam logic [pw:0]   n_src_c = (pw + 1)'(n_src);

  logic [n_src-1:0] r_gnt;
  logic [width-1:0] r_din;
  logic             r_push;
  logic [pw-1:0]    r_ptr;
  logic [cw-1:0]    r_count;
  logic             r_ovf;

  logic [n_src-1:0] w_elig;
  logic             w_pop_eff;
  logic             w_space;
  logic             w_found;
  logic             w_grant;
  logic [pw:0]      w_idx;
  logic [pw-1:0]    w_winner;
  logic [n_src-1:0] w_onehot;
  logic [cw-1:0]    w_count_next;

  // A source granted this cycle still holds the same data, so mask it out.
  assign w_elig    = bus.req & ~r_gnt;
  assign w_pop_eff = bus.fifo_pop && bus.fifo_pndng;
  assign w_space   = (r_count < depth_c) || w_pop_eff;

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_idx    = '0;
    for (int k = 1; k <= n_src; k++) begin
      w_idx = {1'b0, r_ptr} + (pw + 1)'(k);
      if (w_idx >= n_src_c) begin
        w_idx = w_idx - n_src_c;
      end
      if (!w_found && w_elig[w_idx[pw-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[pw-1:0];
      end
    end
  end

  assign w_grant  = w_found && w_space;
  assign w_onehot = n_src'(1) << w_winner;

  // Count is bumped at the grant edge so it already covers the in-flight push.
  always_comb begin
    w_count_next = r_count;
    if (w_grant && !w_pop_eff) begin
      w_count_next = r_count + one_c;
    end else if (!w_grant && w_pop_eff && (r_count != '0)) begin
      w_count_next = r_count - one_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gnt   <= '0;
      r_din   <= '0;
      r_push  <= 1'b0;
      r_ptr   <= pw'(n_src - 1);
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (r_push && bus.fifo_full && !bus.fifo_pop) begin
        r_ovf <= 1'b1;
      end
      if (w_grant) begin
        r_din  <= bus.data_in[w_winner*width +: width];
        r_push <= 1'b1;
        r_gnt  <= w_onehot;
        r_ptr  <= w_winner;
      end else begin
        r_push <= 1'b0;
        r_gnt  <= '0;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.fifo_din  = r_din;
  assign bus.fifo_push = r_push;
  assign bus.count     = r_count;
  assign bus.ovf_err   = r_ovf;

`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [15:0] r_grant_cnt [n_src];
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < n_src; i++) begin
        r_grant_cnt[i] <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < n_src; i++) begin
        if (w_grant && (w_winner == pw'(i)) && (r_grant_cnt[i] != 16'hFFFF)) begin
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
        end
      end
      if ((|bus.req) && !w_space && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < n_src; g++) begin : g_stats
    assign bus.grant_cnt[g*16 +: 16] = r_grant_cnt[g];
  end
  assign bus.stall_cnt = r_stall_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif
endmodule
